// File: rtl/game_sequencer.sv
// Top-level controller for binary_refinement: mode FSM, game timer, LFSR challenge,
// saturating score, name entry and leaderboard. Every output is a register.
module game_sequencer #(
  parameter int         GAME_TIME   = 20,
  parameter int         RESULT_TIME = 2,
  parameter int         PENALTY     = 5,
  parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_1hz,
  input  logic        newgame_p,
  input  logic        newplayer_p,
  input  logic        score_p,
  input  logic        submit_p,
  input  logic [7:0]  sw,
  input  logic        key_valid,
  input  logic [3:0]  key_val,
  output logic [2:0]  mode,
  output logic [7:0]  challenge,
  output logic [5:0]  time_left,
  output logic        is_correct,
  output logic [15:0] your_score,
  output logic [3:0]  name0,
  output logic [3:0]  name1,
  output logic [3:0]  name2,
  output logic [1:0]  name_cnt,
  output logic [15:0] leader_score,
  output logic [3:0]  leader_name0,
  output logic [3:0]  leader_name1,
  output logic [3:0]  leader_name2
);

  typedef enum logic [2:0] {
    MODE_SCORE     = 3'b000,
    MODE_LEADER    = 3'b001,
    MODE_GAME      = 3'b010,
    MODE_RESULT    = 3'b011,
    MODE_NEWPLAYER = 3'b100
  } mode_t;

  localparam logic signed [16:0] NEG_PEN  = 17'(-PENALTY);
  localparam logic [5:0]         GT       = 6'(GAME_TIME);
  localparam logic [5:0]         GT_LAST  = 6'(GAME_TIME - 1);
  localparam logic [3:0]         RES_LAST = 4'(RESULT_TIME - 1);

  mode_t              r_mode, w_mode_next;
  logic [7:0]         r_lfsr, w_lfsr_next;
  logic [7:0]         r_challenge, w_challenge_next;
  logic [5:0]         r_elapsed, w_elapsed_next;
  logic [5:0]         r_time_left, w_time_left_next;
  logic [3:0]         r_res_cnt, w_res_cnt_next;
  logic               r_is_correct, w_is_correct_next;
  logic signed [15:0] r_score, w_score_next;
  logic [3:0]         r_name [3];
  logic [3:0]         w_name_next [3];
  logic [1:0]         r_name_cnt, w_name_cnt_next;
  logic signed [15:0] r_leader_score, w_leader_score_next;
  logic [3:0]         r_leader_name [3];
  logic [3:0]         w_leader_name_next [3];

  logic signed [16:0] w_points;
  logic               w_lfsr_fb;

  // Widen by one bit so overflow is visible, then clamp to the 16-bit range.
  function automatic logic signed [15:0] sat_add(input logic signed [15:0] a,
                                                 input logic signed [16:0] b);
    logic signed [16:0] s;
    s = {a[15], a} + b;
    if (s > 17'sd32767)
      return 16'sh7FFF;
    else if (s < -17'sd32768)
      return 16'sh8000;
    else
      return s[15:0];
  endfunction

  assign w_points  = $signed(17'(GAME_TIME) - {11'd0, r_elapsed});
  assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

  always_comb begin
    w_mode_next         = r_mode;
    w_lfsr_next         = {r_lfsr[6:0], w_lfsr_fb};
    w_challenge_next    = r_challenge;
    w_elapsed_next      = r_elapsed;
    w_time_left_next    = r_time_left;
    w_res_cnt_next      = r_res_cnt;
    w_is_correct_next   = r_is_correct;
    w_score_next        = r_score;
    w_name_cnt_next     = r_name_cnt;
    w_leader_score_next = r_leader_score;
    for (int i = 0; i < 3; i++) begin
      w_name_next[i]        = r_name[i];
      w_leader_name_next[i] = r_leader_name[i];
    end

    case (r_mode)
      MODE_SCORE, MODE_LEADER: begin
        if (newplayer_p) begin
          w_mode_next     = MODE_NEWPLAYER;
          w_name_cnt_next = 2'd0;
          for (int i = 0; i < 3; i++) w_name_next[i] = 4'd0;
        end else if (newgame_p) begin
          w_mode_next      = MODE_GAME;
          w_challenge_next = r_lfsr;
          w_elapsed_next   = 6'd0;
          w_time_left_next = GT;
        end else if (score_p) begin
          w_mode_next = (r_mode == MODE_SCORE) ? MODE_LEADER : MODE_SCORE;
        end
      end

      MODE_GAME: begin
        // A submit landing on the same cycle as a tick is scored on the pre-tick time.
        if (submit_p) begin
          w_mode_next    = MODE_RESULT;
          w_res_cnt_next = 4'd0;
          if (sw == r_challenge) begin
            w_is_correct_next = 1'b1;
            w_score_next      = sat_add(r_score, w_points);
          end else begin
            w_is_correct_next = 1'b0;
            w_score_next      = sat_add(r_score, NEG_PEN);
          end
        end else if (tick_1hz) begin
          w_elapsed_next   = r_elapsed + 6'd1;
          w_time_left_next = r_time_left - 6'd1;
          if (r_elapsed == GT_LAST) begin
            w_mode_next       = MODE_RESULT;
            w_res_cnt_next    = 4'd0;
            w_is_correct_next = 1'b0;
            w_score_next      = sat_add(r_score, NEG_PEN);
          end
        end
      end

      MODE_RESULT: begin
        if (tick_1hz) begin
          if (r_res_cnt == RES_LAST) begin
            w_mode_next = MODE_SCORE;
            if (r_score > r_leader_score) begin
              w_leader_score_next = r_score;
              for (int i = 0; i < 3; i++) w_leader_name_next[i] = r_name[i];
            end
          end else begin
            w_res_cnt_next = r_res_cnt + 4'd1;
          end
        end
      end

      MODE_NEWPLAYER: begin
        if (key_valid && r_name_cnt != 2'd3) begin
          w_name_next[2]  = r_name[1];
          w_name_next[1]  = r_name[0];
          w_name_next[0]  = key_val;
          w_name_cnt_next = r_name_cnt + 2'd1;
        end
        if (submit_p && r_name_cnt == 2'd3) begin
          w_score_next = 16'sd0;
          w_mode_next  = MODE_SCORE;
        end
      end

      default: w_mode_next = MODE_NEWPLAYER;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode         <= MODE_NEWPLAYER;
      r_lfsr         <= LFSR_SEED;
      r_challenge    <= 8'd0;
      r_elapsed      <= 6'd0;
      r_time_left    <= GT;
      r_res_cnt      <= 4'd0;
      r_is_correct   <= 1'b0;
      r_score        <= 16'sd0;
      r_name_cnt     <= 2'd0;
      r_leader_score <= 16'sd0;
      for (int i = 0; i < 3; i++) begin
        r_name[i]        <= 4'd0;
        r_leader_name[i] <= 4'd0;
      end
    end else begin
      r_mode         <= w_mode_next;
      r_lfsr         <= w_lfsr_next;
      r_challenge    <= w_challenge_next;
      r_elapsed      <= w_elapsed_next;
      r_time_left    <= w_time_left_next;
      r_res_cnt      <= w_res_cnt_next;
      r_is_correct   <= w_is_correct_next;
      r_score        <= w_score_next;
      r_name_cnt     <= w_name_cnt_next;
      r_leader_score <= w_leader_score_next;
      for (int i = 0; i < 3; i++) begin
        r_name[i]        <= w_name_next[i];
        r_leader_name[i] <= w_leader_name_next[i];
      end
    end
  end

  assign mode         = r_mode;
  assign challenge    = r_challenge;
  assign time_left    = r_time_left;
  assign is_correct   = r_is_correct;
  assign your_score   = r_score;
  assign name0        = r_name[0];
  assign name1        = r_name[1];
  assign name2        = r_name[2];
  assign name_cnt     = r_name_cnt;
  assign leader_score = r_leader_score;
  assign leader_name0 = r_leader_name[0];
  assign leader_name1 = r_leader_name[1];
  assign leader_name2 = r_leader_name[2];

endmodule

// File: doc/game_sequencer.md
# game_sequencer

Top-level game controller for `binary_refinement`. It owns the mode register, the per-game timer, random challenge generation, scoring, name entry and the leaderboard record. It consumes single-cycle pulses from the debouncers, decoded keypad values and a 1 Hz tick. Its registered outputs drive the display demux and the seven-segment formatting.

## Interface
Parameters:
- `GAME_TIME`, 20: game length in seconds and maximum points per challenge (1..63).
- `RESULT_TIME`, 2: seconds spent in RESULT mode (1..15).
- `PENALTY`, 5: points subtracted for a wrong answer or a timeout.
- `LFSR_SEED`, 8'hA5: LFSR reset value; must be non-zero.

Ports (clock and reset first):
- `clk`  in  1  system clock, 100 MHz.
- `rst`  in  1  synchronous, active-high reset.
- `tick_1hz`  in  1  one-cycle pulse once per second.
- `newgame_p`  in  1  debounced new-game button, one-cycle pulse.
- `newplayer_p`  in  1  debounced new-player button, one-cycle pulse.
- `score_p`  in  1  debounced score/leaderboard toggle, one-cycle pulse.
- `submit_p`  in  1  debounced submit button, one-cycle pulse.
- `sw`  in  8  player answer, unsigned.
- `key_valid`  in  1  one-cycle pulse; `key_val` is valid.
- `key_val`  in  4  keypad digit, 0x0..0xF.
- `mode`  out  3  000 SCORE, 001 LEADER, 010 GAME, 011 RESULT, 100 NEWPLAYER.
- `challenge`  out  8  current target value.
- `time_left`  out  6  `GAME_TIME` minus elapsed seconds.
- `is_correct`  out  1  result of the last game.
- `your_score`  out  16  signed current player score.
- `name0`/`name1`/`name2`  out  4 each  current player name; `name0` is the newest digit.
- `name_cnt`  out  2  digits entered, 0..3.
- `leader_score`  out  16  signed best score.
- `leader_name0`/`leader_name1`/`leader_name2`  out  4 each  leader's name.

## Operation
- All outputs are registered. State changes on the clock edge after the qualifying input cycle.
- **Reset values:** `mode`=NEWPLAYER, `challenge`=0, `time_left`=`GAME_TIME`, `is_correct`=0, `your_score`=0, all name digits 0, `name_cnt`=0, `leader_score`=0, leader name digits 0, LFSR=`LFSR_SEED`.
- **LFSR:** 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. Advances every cycle in every mode, never zero.
- **SCORE/LEADER:**
  - Input priority per cycle: `newplayer_p` > `newgame_p` > `score_p`. Lower-priority pulses in the same cycle are dropped.
  - `score_p` toggles SCORE<->LEADER.
  - `newgame_p` enters GAME: `challenge`<=LFSR value, elapsed<=0, `time_left`<=`GAME_TIME`.
  - `newplayer_p` enters NEWPLAYER and clears name digits and `name_cnt`.
  - `submit_p` is ignored.
- **GAME:**
  - Each `tick_1hz` increments elapsed and decrements `time_left`.
  - `submit_p` with `sw`==`challenge`: `is_correct`<=1, `your_score` += `GAME_TIME` - elapsed, go to RESULT.
  - `submit_p` with `sw`!=`challenge`: `is_correct`<=0, `your_score` -= `PENALTY`, go to RESULT.
  - Timeout: a tick arriving while elapsed==`GAME_TIME`-1 sets `is_correct`<=0, applies the penalty and goes to RESULT.
  - Submit and tick in the same cycle: submit wins, and points use the pre-tick elapsed value.
  - All other buttons are ignored.
- **RESULT:**
  - Result counter cleared on entry; it counts ticks.
  - On the `RESULT_TIME`-th tick: go to SCORE. In the same edge, if signed `your_score` > `leader_score`, copy score and name into the leader registers. Ties keep the old leader.
  - All buttons are ignored.
- **NEWPLAYER:**
  - `key_valid` with `name_cnt`<3: shift `name2`<=`name1`, `name1`<=`name0`, `name0`<=`key_val`, `name_cnt`++.
  - `key_valid` with `name_cnt`==3: ignored.
  - `submit_p` with `name_cnt`==3: `your_score`<=0, go to SCORE. With fewer digits it is ignored.
  - Other buttons are ignored.
- **Score arithmetic:** signed 16-bit, saturating at +32767 and -32768.
- **Reset mid-game:** all state returns to reset values; no score or leader update occurs.

## Timing
- Button pulse sampled in cycle N: `mode` and all affected registers are updated at the edge ending cycle N and visible in cycle N+1.
- `challenge` is stable for the whole GAME and RESULT period.
- RESULT duration is between `RESULT_TIME`-1 and `RESULT_TIME` seconds, depending on tick phase at entry.
- Inputs are assumed synchronous to `clk`. Pulses longer than one cycle are treated as repeated events; debouncers must deliver single-cycle pulses.

## Test plan
- Reset, then keys 1,2,3 and submit: name0=3, name1=2, name2=1, `name_cnt`=3, `mode`=000, `your_score`=0. A submit after only 2 keys leaves `mode`=100.
- From SCORE, newgame, 4 ticks, then `sw`=`challenge` and submit: `mode`=011, `is_correct`=1, `your_score`=16. After 2 ticks `mode`=000, `leader_score`=16, leader name 1,2,3.
- Newgame, then 20 ticks with no submit: on the 20th tick `mode`=011, `is_correct`=0, `your_score` decreases by 5. A leader with a higher score is unchanged.
- Wrong answer when `your_score`=-32766: saturates to -32768.
- Same-cycle `newplayer_p`+`newgame_p` in SCORE: `mode`=100. Same-cycle submit+tick at elapsed=19 with a correct `sw`: `is_correct`=1, +1 point.
- Assert `rst` during GAME at elapsed=7: next cycle `mode`=100, `your_score`=0, `time_left`=20, `leader_score` is 0.
